// File: rtl/avaliador_tentativas.sv
// Guessing-game evaluator: samples comparator flags on a confirmed press, counts attempts, drives hints and win/loss.
// Confirm-button debounce is included when AVALIADOR_DEBOUNCE_EN is defined.
module avaliador_tentativas #(
   parameter int MAX_TENTATIVAS  = 7,
   parameter int CNT_W           = 3,
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             confirma,
   input  logic             reinicia,
   input  logic             maior,
   input  logic             menor,
   input  logic             igual,
   output logic [CNT_W-1:0] tentativas,
   output logic             led_maior,
   output logic             led_menor,
   output logic             acertou,
   output logic             perdeu,
   output logic             erro
);

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      AVALIA  = 2'd1,
      ACERTO  = 2'd2,
      DERROTA = 2'd3
   } estado_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TENTATIVAS);
   localparam logic [CNT_W-1:0] UM_CNT  = CNT_W'(1);

   if ((MAX_TENTATIVAS < 1) || (MAX_TENTATIVAS > (2 ** CNT_W) - 1) || (DEBOUNCE_CICLOS < 1)) begin : g_param_invalido
      $error("avaliador_tentativas: parameter out of legal range");
   end

   // Exactly one of three flags set: odd parity excluding the all-ones case
   function automatic logic um_quente(input logic a, input logic b, input logic c);
      return (a ^ b ^ c) & ~(a & b & c);
   endfunction

   logic             s0_r;
   logic             s1_r;
   logic             p_r;
   logic             nivel_s;
   logic             pulso_s;
   logic             flags_ok_s;
   logic [CNT_W-1:0] tent_inc_s;

   estado_t          estado_r;
   logic [CNT_W-1:0] tentativas_r;
   logic             led_maior_r;
   logic             led_menor_r;
   logic             acertou_r;
   logic             perdeu_r;
   logic             erro_r;

   // Two-flop synchronizer for the asynchronous button level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_r <= 1'b0;
         s1_r <= 1'b0;
      end else begin
         s0_r <= confirma;
         s1_r <= s0_r;
      end
   end

`ifdef AVALIADOR_DEBOUNCE_EN
   localparam int               DEB_W   = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CICLOS);
   localparam logic [DEB_W-1:0] DEB_UM  = DEB_W'(1);

   logic [DEB_W-1:0] deb_cnt_r;

   // Count consecutive synchronized-high cycles, saturating at the threshold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt_r <= {DEB_W{1'b0}};
      end else if (!s1_r) begin
         deb_cnt_r <= {DEB_W{1'b0}};
      end else if (deb_cnt_r != DEB_MAX) begin
         deb_cnt_r <= deb_cnt_r + DEB_UM;
      end else begin
         deb_cnt_r <= deb_cnt_r;
      end
   end

   // Debounced level drops as soon as the synchronized input is low
   assign nivel_s = s1_r & (deb_cnt_r == DEB_MAX);
`else
   assign nivel_s = s1_r;
`endif

   // Previous-value flop for rising-edge detection of the button level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r <= 1'b0;
      end else begin
         p_r <= nivel_s;
      end
   end

   assign pulso_s    = nivel_s & ~p_r;
   assign flags_ok_s = um_quente(maior, menor, igual);
   assign tent_inc_s = tentativas_r + UM_CNT;

   // Game FSM with registered outputs; reinicia overrides any pending press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_r     <= ESPERA;
         tentativas_r <= {CNT_W{1'b0}};
         led_maior_r  <= 1'b0;
         led_menor_r  <= 1'b0;
         acertou_r    <= 1'b0;
         perdeu_r     <= 1'b0;
         erro_r       <= 1'b0;
      end else if (reinicia) begin
         estado_r     <= ESPERA;
         tentativas_r <= {CNT_W{1'b0}};
         led_maior_r  <= 1'b0;
         led_menor_r  <= 1'b0;
         acertou_r    <= 1'b0;
         perdeu_r     <= 1'b0;
         erro_r       <= 1'b0;
      end else begin
         erro_r <= 1'b0;
         case (estado_r)
            ESPERA: begin
               if (pulso_s) begin
                  estado_r <= AVALIA;
               end else begin
                  estado_r <= ESPERA;
               end
            end
            AVALIA: begin
               if (!flags_ok_s) begin
                  erro_r   <= 1'b1;
                  estado_r <= ESPERA;
               end else if (igual) begin
                  tentativas_r <= tent_inc_s;
                  led_maior_r  <= 1'b0;
                  led_menor_r  <= 1'b0;
                  acertou_r    <= 1'b1;
                  estado_r     <= ACERTO;
               end else if (tent_inc_s == MAX_CNT) begin
                  tentativas_r <= tent_inc_s;
                  led_maior_r  <= 1'b0;
                  led_menor_r  <= 1'b0;
                  perdeu_r     <= 1'b1;
                  estado_r     <= DERROTA;
               end else begin
                  tentativas_r <= tent_inc_s;
                  led_maior_r  <= maior;
                  led_menor_r  <= menor;
                  estado_r     <= ESPERA;
               end
            end
            ACERTO: begin
               estado_r <= ACERTO;
            end
            DERROTA: begin
               estado_r <= DERROTA;
            end
            default: begin
               estado_r <= ESPERA;
            end
         endcase
      end
   end

   assign tentativas = tentativas_r;
   assign led_maior  = led_maior_r;
   assign led_menor  = led_menor_r;
   assign acertou    = acertou_r;
   assign perdeu     = perdeu_r;
   assign erro       = erro_r;

endmodule

// File: tb/tb_avaliador_tentativas.sv
// Scoreboard bench for avaliador_tentativas: expected output vectors are queued per press and checked at output time.
`timescale 1ns/1ps
module tb_avaliador_tentativas;

   localparam int MAX_T = 7;
   localparam int CNT_W = 3;
`ifdef AVALIADOR_DEBOUNCE_EN
   localparam int LAT = 4 + 16;
`else
   localparam int LAT = 4;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             confirma = 1'b0;
   logic             reinicia = 1'b0;
   logic             maior = 1'b0;
   logic             menor = 1'b0;
   logic             igual = 1'b0;
   logic [CNT_W-1:0] tentativas;
   logic             led_maior;
   logic             led_menor;
   logic             acertou;
   logic             perdeu;
   logic             erro;
   logic [7:0]       obs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] v;
      string      nome;
   } exp_t;

   exp_t sb_q[$];

   int   m_tent;
   logic m_lma, m_lme, m_ac, m_pe;

   always #5 clk = ~clk;

   assign obs = {tentativas, led_maior, led_menor, acertou, perdeu, erro};

   avaliador_tentativas #(
      .MAX_TENTATIVAS (MAX_T),
      .CNT_W          (CNT_W),
      .DEBOUNCE_CICLOS(16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .confirma  (confirma),
      .reinicia  (reinicia),
      .maior     (maior),
      .menor     (menor),
      .igual     (igual),
      .tentativas(tentativas),
      .led_maior (led_maior),
      .led_menor (led_menor),
      .acertou   (acertou),
      .perdeu    (perdeu),
      .erro      (erro)
   );

   function automatic logic [7:0] pack(input int t, input logic lma, input logic lme,
                                       input logic ac, input logic pe, input logic er);
      logic [CNT_W-1:0] tc;
      tc = CNT_W'(t);
      return {tc, lma, lme, ac, pe, er};
   endfunction

   task automatic model_clear();
      m_tent = 0;
      m_lma  = 1'b0;
      m_lme  = 1'b0;
      m_ac   = 1'b0;
      m_pe   = 1'b0;
   endtask

   // One button press with flags f = {maior, menor, igual}
   task automatic press(input logic [2:0] f, input string nome);
      exp_t       e;
      logic [7:0] antes;
      logic       er;
      antes = pack(m_tent, m_lma, m_lme, m_ac, m_pe, 1'b0);
      er = 1'b0;
      if (!(m_ac || m_pe)) begin
         if (f != 3'b100 && f != 3'b010 && f != 3'b001) begin
            er = 1'b1;
         end else if (f == 3'b001) begin
            m_tent++; m_lma = 1'b0; m_lme = 1'b0; m_ac = 1'b1;
         end else if (m_tent + 1 == MAX_T) begin
            m_tent++; m_lma = 1'b0; m_lme = 1'b0; m_pe = 1'b1;
         end else begin
            m_tent++; m_lma = f[2]; m_lme = f[1];
         end
      end
      e.v = pack(m_tent, m_lma, m_lme, m_ac, m_pe, er);
      e.nome = nome;
      sb_q.push_back(e);
      {maior, menor, igual} = f;
      @(posedge clk); #1 confirma = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== antes) begin
         n_fail++;
         $display("FAIL %s_latency: outputs %b, required %b one edge before update", nome, obs, antes);
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e.v) begin
         n_fail++;
         $display("FAIL %s: outputs %b, required %b", e.nome, obs, e.v);
      end
      @(posedge clk); #1;
      n_checks++;
      if (obs !== {e.v[7:1], 1'b0}) begin
         n_fail++;
         $display("FAIL %s_hold: outputs %b, required %b", e.nome, obs, {e.v[7:1], 1'b0});
      end
      confirma = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reinicia(input string nome);
      @(posedge clk); #1 reinicia = 1'b1;
      @(posedge clk); #1 reinicia = 1'b0;
      model_clear();
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL %s: outputs %b, required 00000000", nome, obs);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_active: outputs %b, required 00000000", obs);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_release: outputs %b, required 00000000", obs);
      end
   endtask

   task automatic test_hint();
      press(3'b100, "hint_maior");
      press(3'b010, "hint_menor");
   endtask

   task automatic test_win();
      do_reinicia("win_clear");
      press(3'b010, "win_menor");
      press(3'b001, "win_igual");
      press(3'b100, "win_ignored");
   endtask

   task automatic test_loss();
      do_reinicia("loss_clear");
      for (int i = 0; i < MAX_T + 1; i++) begin
         press(3'b100, $sformatf("loss_press%0d", i + 1));
      end
   endtask

   task automatic test_erro();
      do_reinicia("erro_clear");
      press(3'b000, "erro_none");
      press(3'b110, "erro_two");
      press(3'b100, "erro_valid");
      press(3'b011, "erro_leds_kept");
      press(3'b111, "erro_three");
   endtask

   task automatic test_held();
      do_reinicia("held_clear");
      {maior, menor, igual} = 3'b010;
      @(posedge clk); #1 confirma = 1'b1;
      repeat (LAT + 12) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== pack(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL held_single: outputs %b, required %b", obs, pack(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      confirma = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      m_tent = 1; m_lme = 1'b1;
      press(3'b100, "held_release_then_press");
   endtask

   task automatic test_reinicia_priority();
      do_reinicia("prio_clear");
      press(3'b001, "prio_win");
      for (int k = 0; k < 2; k++) begin
         {maior, menor, igual} = 3'b001;
         @(posedge clk); #1 confirma = 1'b1;
         repeat (LAT - 2) @(posedge clk);
         #1 reinicia = 1'b1;
         @(posedge clk); #1 reinicia = 1'b0;
         model_clear();
         n_checks++;
         if (obs !== 8'd0) begin
            n_fail++;
            $display("FAIL prio_clear_%0d: outputs %b, required 00000000", k, obs);
         end
         repeat (LAT + 2) @(posedge clk);
         #1;
         n_checks++;
         if (obs !== 8'd0) begin
            n_fail++;
            $display("FAIL prio_no_eval_%0d: outputs %b, required 00000000", k, obs);
         end
         confirma = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      do_reinicia("mid_clear");
      press(3'b100, "mid_first");
      {maior, menor, igual} = 3'b010;
      @(posedge clk); #1 confirma = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_async: outputs %b, required 00000000", obs);
      end
      @(posedge clk); #1;
      confirma = 1'b0;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      model_clear();
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_no_partial: outputs %b, required 00000000", obs);
      end
   endtask

`ifdef AVALIADOR_DEBOUNCE_EN
   task automatic test_debounce();
      do_reinicia("deb_clear");
      {maior, menor, igual} = 3'b010;
      @(posedge clk); #1 confirma = 1'b1;
      repeat (10) @(posedge clk);
      #1 confirma = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 8'd0) begin
         n_fail++;
         $display("FAIL deb_glitch: outputs %b, required 00000000", obs);
      end
      press(3'b010, "deb_press");
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model_clear();
      test_reset();
      test_hint();
      test_win();
      test_loss();
      test_erro();
      test_held();
      test_reinicia_priority();
      test_reset_mid();
`ifdef AVALIADOR_DEBOUNCE_EN
      test_debounce();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
